// File: rtl/ifetch_decode_if.sv
// Fetch/decode bus bundle: instruction-memory port, PC redirect, decoded output stream.
// The master side is the fetch/decode block; the slave side is memory plus consumer.
interface ifetch_decode_if;
  logic [7:0] imem_addr;
  logic [7:0] imem_instr;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_op;
  logic [1:0] out_rs;
  logic [1:0] out_rt;
  logic [1:0] out_rd;
  logic [7:0] out_imm;
  logic [7:0] out_pc;
  logic       halted;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_op,
    output out_rs,
    output out_rt,
    output out_rd,
    output out_imm,
    output out_pc,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_op,
    input  out_rs,
    input  out_rt,
    input  out_rd,
    input  out_imm,
    input  out_pc,
    input  halted
  );
endinterface

// File: rtl/ifetch_decode.sv
// Instruction fetch + decode into a 2-entry buffer with RUN/HALT fetch FSM.
// Define IFETCH_JUMP_EN to make op 2'b11 a PC-relative jump; otherwise fetch is purely sequential.
module ifetch_decode #(
  parameter int PROG_LEN   = 12,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  ifetch_decode_if.master bus
);

  localparam logic [8:0] PROG_LEN_W = 9'(PROG_LEN);
  localparam logic [1:0] DEPTH_W    = 2'(FIFO_DEPTH);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] rd;
    logic [7:0] imm;
    logic [7:0] pc;
  } entry_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_pc;
  logic [1:0] r_count;
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  entry_t     r_fifo [FIFO_DEPTH];

  entry_t     w_entry;
  entry_t     w_head;
  logic [7:0] w_pc_seq;
  logic [7:0] w_next_pc;
  logic       w_push;
  logic       w_pop;

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_entry    = '0;
    w_entry.op = bus.imem_instr[7:6];
    w_entry.rs = bus.imem_instr[5:4];
    w_entry.rt = bus.imem_instr[3:2];
    w_entry.rd = bus.imem_instr[1:0];
    w_entry.pc = r_pc;
    if (bus.imem_instr[7:6] == 2'b11)
      w_entry.imm = {{2{bus.imem_instr[5]}}, bus.imem_instr[5:0]};
    else
      w_entry.imm = {{6{bus.imem_instr[1]}}, bus.imem_instr[1:0]};
  end

  assign w_pc_seq = r_pc + 8'd1;

`ifdef IFETCH_JUMP_EN
  assign w_next_pc = (bus.imem_instr[7:6] == 2'b11) ? (w_pc_seq + w_entry.imm) : w_pc_seq;
`else
  assign w_next_pc = w_pc_seq;
`endif

  // Redirect outranks both push and pop: the buffer is flushed regardless of the handshake.
  assign w_pop  = (r_count != 2'd0) && bus.out_ready && !bus.redirect_valid;
  assign w_push = (r_state == ST_RUN) && !bus.redirect_valid && ((r_count < DEPTH_W) || w_pop);

  always_comb begin
    w_state_next = r_state;
    if (bus.redirect_valid)
      w_state_next = ({1'b0, bus.redirect_pc} < PROG_LEN_W) ? ST_RUN : ST_HALT;
    else if (w_push && ({1'b0, w_next_pc} >= PROG_LEN_W))
      w_state_next = ST_HALT;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= (PROG_LEN == 0) ? ST_HALT : ST_RUN;
    else        r_state <= w_state_next;
  end

  // NOTE: the buffer entries are reset too, because the head fields are visible outputs with defined reset values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc     <= 8'd0;
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else if (bus.redirect_valid) begin
      r_pc     <= bus.redirect_pc;
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_entry;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
        r_pc             <= w_next_pc;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head = r_fifo[r_rd_ptr];

  assign bus.imem_addr = r_pc;
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_op    = w_head.op;
  assign bus.out_rs    = w_head.rs;
  assign bus.out_rt    = w_head.rt;
  assign bus.out_rd    = w_head.rd;
  assign bus.out_imm   = w_head.imm;
  assign bus.out_pc    = w_head.pc;
  assign bus.halted    = (r_state == ST_HALT);

endmodule
